branch_predictor_table: RTL
===========================

Name: branch_predictor_table

Overview:
- Parametrised successor to the single 2-bit saturating-counter branch predictor.
- Holds a pattern history table (PHT) of 2^INDEX_BITS saturating counters of CTR_WIDTH bits each.
- Selectable index mode: bimodal (PC-indexed) or gshare (PC XOR global history).
- Sits beside fetch. Lookups come from the fetch stage. Resolved outcomes return from execute with the index echoed back. The block also keeps a saturating mispredict counter for performance monitoring.

Parameters:
- PC_WIDTH, 32, width of the lookup PC.
- INDEX_BITS, 4, log2 of PHT entries; range 1..12.
- CTR_WIDTH, 2, bits per saturating counter; range 1..4.
- HIST_BITS, 4, global history length; must be <= INDEX_BITS.
- MODE, 0, 0 = bimodal, 1 = gshare.
- INIT_STATE, 1, counter value loaded on reset; must be < 2^CTR_WIDTH.

Ports:
- i_clock  in  1  rising-edge clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_lookup_valid  in  1  lookup request this cycle.
- i_lookup_pc  in  PC_WIDTH  branch PC.
- o_pred_valid  out  1  prediction outputs valid.
- o_pred_taken  out  1  predicted direction (counter MSB).
- o_pred_index  out  INDEX_BITS  PHT index used; the pipeline echoes it on update.
- o_pred_state  out  CTR_WIDTH  raw counter value read.
- i_update_valid  in  1  resolved branch this cycle.
- i_update_index  in  INDEX_BITS  entry to train.
- i_update_taken  in  1  actual outcome.
- i_update_mispredict  in  1  the earlier prediction was wrong.
- o_history  out  HIST_BITS  current global history register (GHR).
- o_mispredict_count  out  16  saturating mispredict count.

Behaviour:
- Reset (i_reset_n low, asynchronous, any cycle including mid-lookup):
  - all PHT entries = INIT_STATE;
  - GHR = 0;
  - o_pred_valid, o_pred_taken, o_pred_index, o_pred_state = 0;
  - o_mispredict_count = 0;
  - any in-flight lookup is dropped.
  - After reset deasserts, the first edge with i_lookup_valid=1 produces a valid prediction on the next cycle.
- Index computation:
  - raw = i_lookup_pc[INDEX_BITS+1:2].
  - MODE 0: idx = raw.
  - MODE 1: idx = raw XOR {zero-extend GHR to INDEX_BITS}.
- Lookup latency is 1 cycle, registered.
  - Edge N with i_lookup_valid=1 sets o_pred_valid=1 at N+1, with o_pred_index=idx, o_pred_state=PHT[idx] and o_pred_taken=PHT[idx][CTR_WIDTH-1].
  - Edge with i_lookup_valid=0 clears o_pred_valid. The other prediction outputs hold their last values.
  - No stall input. A lookup every cycle is supported.
- Update on a clock edge with i_update_valid=1:
  - i_update_taken=1: counter increments, saturating at 2^CTR_WIDTH-1.
  - i_update_taken=0: counter decrements, saturating at 0.
  - No wrap-around in either direction.
  - GHR shifts left with i_update_taken entering at bit 0 (non-speculative history). The GHR updates in both modes.
  - i_update_mispredict=1 increments o_mispredict_count, saturating at 16'hFFFF.
  - i_update_mispredict is ignored when i_update_valid=0.
- Simultaneous lookup and update on the same edge:
  - The PHT read is read-before-write: the prediction reflects the pre-update counter.
  - The gshare index uses the pre-update GHR.
  - Different indices are fully independent.
  - The update index is taken from i_update_index, never recomputed, so GHR movement cannot misdirect training.
- CTR_WIDTH=1 degenerates to a last-outcome predictor; the same rules apply.
- All state lives in flops with no memory macro, so a reset clears the whole table in a single event.

Test Plan:
- Saturation up: MODE 0, reset. Issue 8 updates of idx 3 with taken=1, and a lookup after each using pc=32'h0000000C. Required o_pred_state sequence: 2,3,3,3,3,3,3,3. o_pred_taken is 1 from the first update onward.
- Saturation down and alternation:
  - Issue 4 not-taken updates on idx 5. The counter reaches 0 and stays at 0.
  - Then apply the pattern 0,1,0,1,... The state toggles 0,1,0,1 and o_pred_taken stays 0 throughout.
- Read-before-write: idx 2 at state 1. On the same edge, look up pc=32'h00000008 and update idx 2 taken. Required: o_pred_state=1, o_pred_taken=0. A following lookup returns state 2, taken 1.
- Gshare indexing: MODE 1. Updates taken,taken,not-taken,taken leave GHR=4'b1101. Lookup with pc=32'h00000010 (raw=4) gives o_pred_index=4'b1001 and o_history=4'b1101.
- Mispredict counter: 5 updates with mispredict=1, plus 2 with i_update_valid=0 and mispredict=1. Required o_mispredict_count=5. Forcing the count to FFFF and adding one more mispredict update keeps it at FFFF.
- Reset mid-operation:
  - Assert i_reset_n=0 asynchronously between edges while o_pred_valid=1 and several entries are trained. The outputs clear immediately, without waiting for an edge.
  - After release, a lookup of every index returns INIT_STATE=1 and GHR=0.

Source files
------------

// File: rtl/branch_predictor_table.sv
// Pattern history table of saturating counters, bimodal or gshare indexed.
// One-cycle registered lookup, non-speculative global history, mispredict counter.
module branch_predictor_table #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 4,
  parameter int CTR_WIDTH  = 2,
  parameter int HIST_BITS  = 4,
  parameter int MODE       = 0,
  parameter int INIT_STATE = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_lookup_valid,
  input  logic [PC_WIDTH-1:0]   i_lookup_pc,
  output logic                  o_pred_valid,
  output logic                  o_pred_taken,
  output logic [INDEX_BITS-1:0] o_pred_index,
  output logic [CTR_WIDTH-1:0]  o_pred_state,
  input  logic                  i_update_valid,
  input  logic [INDEX_BITS-1:0] i_update_index,
  input  logic                  i_update_taken,
  input  logic                  i_update_mispredict,
  output logic [HIST_BITS-1:0]  o_history,
  output logic [15:0]           o_mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(INIT_STATE);
  localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);

  typedef struct packed {
    logic                  valid;
    logic                  taken;
    logic [INDEX_BITS-1:0] index;
    logic [CTR_WIDTH-1:0]  state;
  } pred_t;

  logic [ENTRIES-1:0][CTR_WIDTH-1:0] pht;
  logic [HIST_BITS-1:0]              ghr;
  logic [15:0]                       mis_cnt;
  pred_t                             pred_q;

  logic [INDEX_BITS-1:0] raw_idx, lk_idx;
  logic [CTR_WIDTH-1:0]  rd_state, upd_cur, upd_nxt;
  logic                  unused_pc;

  assign raw_idx   = i_lookup_pc[INDEX_BITS+1:2];
  assign unused_pc = ^{i_lookup_pc[PC_WIDTH-1:INDEX_BITS+2], i_lookup_pc[1:0]};

  generate
    if (MODE == 1) begin : g_gshare
      assign lk_idx = raw_idx ^ INDEX_BITS'(ghr);
    end else begin : g_bimodal
      assign lk_idx = raw_idx;
    end
  endgenerate

  // Both ports read the current table, so a same-edge update is invisible to the lookup.
  assign rd_state = pht[lk_idx];
  assign upd_cur  = pht[i_update_index];

  always_comb begin
    upd_nxt = upd_cur;
    if (i_update_taken) begin
      if (upd_cur != CTR_MAX) upd_nxt = upd_cur + CTR_ONE;
    end else if (upd_cur != '0) begin
      upd_nxt = upd_cur - CTR_ONE;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pht <= {ENTRIES{CTR_INIT}};
    end else if (i_update_valid) begin
      pht[i_update_index] <= upd_nxt;
    end
  end

  // History is trained only by resolved outcomes; the cast keeps the low HIST_BITS.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ghr     <= '0;
      mis_cnt <= '0;
    end else if (i_update_valid) begin
      ghr <= HIST_BITS'({ghr, i_update_taken});
      if (i_update_mispredict && mis_cnt != 16'hFFFF) mis_cnt <= mis_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pred_q <= '0;
    end else if (i_lookup_valid) begin
      pred_q.valid <= 1'b1;
      pred_q.taken <= rd_state[CTR_WIDTH-1];
      pred_q.index <= lk_idx;
      pred_q.state <= rd_state;
    end else begin
      pred_q.valid <= 1'b0;
    end
  end

  assign o_pred_valid       = pred_q.valid;
  assign o_pred_taken       = pred_q.taken;
  assign o_pred_index       = pred_q.index;
  assign o_pred_state       = pred_q.state;
  assign o_history          = ghr;
  assign o_mispredict_count = mis_cnt;

endmodule
